// File: rtl/pbkdf2_arbiter.sv
// Round-robin arbiter that shares one pbkdf2 core among NREQ requesters, one job at a time.
// Optional per-requester completion counters (jobs_done_o) are enabled by defining PBKDF2_ARB_STATS_EN.
module pbkdf2_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NREQ-1:0]       req_v_i,
  output logic [NREQ-1:0]       req_r_o,
  input  logic [NREQ*32-1:0]    req_iters_i,
  input  logic [NREQ*512-1:0]   req_pass_i,
  input  logic [NREQ*512-1:0]   req_salt_i,
  input  logic [NREQ*6-1:0]     req_salt_len_i,
  output logic [NREQ-1:0]       rsp_v_o,
  input  logic [NREQ-1:0]       rsp_r_i,
  output logic [255:0]          rsp_hash_o,
  output logic                  rsp_err_o,
  output logic                  busy_o,
  output logic [IDW-1:0]        owner_o,
  output logic                  core_in_valid_o,
  input  logic                  core_in_ready_i,
  output logic [31:0]           core_iters_o,
  output logic [511:0]          core_pass_o,
  output logic [511:0]          core_salt_o,
  output logic [5:0]            core_salt_len_o,
  input  logic                  core_out_valid_i,
  output logic                  core_out_ready_o,
  input  logic [255:0]          core_hash_i
`ifdef PBKDF2_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0]    jobs_done_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_ZERO  = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [IDW-1:0]  r_owner;
  logic [IDW-1:0]  r_last;
  logic [IDW-1:0]  w_grant;
  logic [IDW-1:0]  w_cand;
  logic [255:0]    r_hash;
  logic            r_err;
  logic [31:0]     w_grant_iters;
  logic            w_rsp_done;

  // Round-robin pick; scanning the far offsets first lets the nearest requester after r_last win.
  always_comb begin
    w_grant = r_last;
    w_cand  = r_last;
    for (int i = NREQ; i >= 1; i--) begin
      w_cand  = IDW'((int'(r_last) + i) % NREQ);
      w_grant = req_v_i[w_cand] ? w_cand : w_grant;
    end
  end

  assign w_grant_iters = req_iters_i[32*w_grant +: 32];
  assign w_rsp_done    = (r_state == S_RESP) && rsp_r_i[r_owner];

  // Next-state decode and handshake outputs; operands reach the core only while issuing.
  always_comb begin
    w_next           = r_state;
    req_r_o          = '0;
    rsp_v_o          = '0;
    core_in_valid_o  = 1'b0;
    core_out_ready_o = 1'b0;
    core_iters_o     = 32'd0;
    core_pass_o      = 512'd0;
    core_salt_o      = 512'd0;
    core_salt_len_o  = 6'd0;
    case (r_state)
      S_IDLE: begin
        if (|req_v_i) begin
          w_next = (w_grant_iters == 32'd0) ? S_ZERO : S_ISSUE;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_ISSUE: begin
        core_in_valid_o = 1'b1;
        core_iters_o    = req_iters_i[32*r_owner +: 32];
        core_pass_o     = req_pass_i[512*r_owner +: 512];
        core_salt_o     = req_salt_i[512*r_owner +: 512];
        core_salt_len_o = req_salt_len_i[6*r_owner +: 6];
        if (core_in_ready_i) begin
          req_r_o[r_owner] = 1'b1;
          w_next           = S_WAIT;
        end else begin
          w_next = S_ISSUE;
        end
      end
      S_ZERO: begin
        req_r_o[r_owner] = 1'b1;
        w_next           = S_RESP;
      end
      S_WAIT: begin
        core_out_ready_o = core_out_valid_i;
        if (core_out_valid_i) begin
          w_next = S_RESP;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_RESP: begin
        rsp_v_o[r_owner] = 1'b1;
        if (rsp_r_i[r_owner]) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_RESP;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State, owner and round-robin pointer; the pointer only advances once a result is taken.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_last  <= IDW'(NREQ - 1);
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && (|req_v_i)) begin
        r_owner <= w_grant;
      end
      if (w_rsp_done) begin
        r_last <= r_owner;
      end
    end
  end

  // Result register: zero-iteration jobs report an error without touching the core.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_hash <= '0;
      r_err  <= 1'b0;
    end else if (r_state == S_ZERO) begin
      r_hash <= '0;
      r_err  <= 1'b1;
    end else if ((r_state == S_WAIT) && core_out_valid_i) begin
      r_hash <= core_hash_i;
      r_err  <= 1'b0;
    end
  end

  assign busy_o     = (r_state != S_IDLE);
  assign owner_o    = r_owner;
  assign rsp_hash_o = r_hash;
  assign rsp_err_o  = r_err;

`ifdef PBKDF2_ARB_STATS_EN
  logic [NREQ*16-1:0] r_jobs;

  // Per-requester completed-job counters, wrapping at 16 bits.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_jobs <= '0;
    end else if (w_rsp_done) begin
      r_jobs[16*r_owner +: 16] <= r_jobs[16*r_owner +: 16] + 16'd1;
    end
  end

  assign jobs_done_o = r_jobs;
`endif

endmodule

// File: tb/tb_pbkdf2_arbiter.sv
// Randomized bench for pbkdf2_arbiter with an emulated core and a transaction-level reference model.
module tb_pbkdf2_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                 clk_i = 1'b0;
  logic                 rst_ni = 1'b0;
  logic [NREQ-1:0]      req_v_i = '0;
  logic [NREQ-1:0]      req_r_o;
  logic [NREQ*32-1:0]   req_iters_i = '0;
  logic [NREQ*512-1:0]  req_pass_i = '0;
  logic [NREQ*512-1:0]  req_salt_i = '0;
  logic [NREQ*6-1:0]    req_salt_len_i = '0;
  logic [NREQ-1:0]      rsp_v_o;
  logic [NREQ-1:0]      rsp_r_i = '0;
  logic [255:0]         rsp_hash_o;
  logic                 rsp_err_o;
  logic                 busy_o;
  logic [IDW-1:0]       owner_o;
  logic                 core_in_valid_o;
  logic                 core_in_ready_i = 1'b0;
  logic [31:0]          core_iters_o;
  logic [511:0]         core_pass_o;
  logic [511:0]         core_salt_o;
  logic [5:0]           core_salt_len_o;
  logic                 core_out_valid_i = 1'b0;
  logic                 core_out_ready_o;
  logic [255:0]         core_hash_i = '0;
`ifdef PBKDF2_ARB_STATS_EN
  logic [NREQ*16-1:0]   jobs_done_o;
`endif

  always #5 clk_i = ~clk_i;

  pbkdf2_arbiter #(.NREQ(NREQ)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_v_i(req_v_i), .req_r_o(req_r_o), .req_iters_i(req_iters_i),
    .req_pass_i(req_pass_i), .req_salt_i(req_salt_i), .req_salt_len_i(req_salt_len_i),
    .rsp_v_o(rsp_v_o), .rsp_r_i(rsp_r_i), .rsp_hash_o(rsp_hash_o), .rsp_err_o(rsp_err_o),
    .busy_o(busy_o), .owner_o(owner_o),
    .core_in_valid_o(core_in_valid_o), .core_in_ready_i(core_in_ready_i),
    .core_iters_o(core_iters_o), .core_pass_o(core_pass_o), .core_salt_o(core_salt_o),
    .core_salt_len_o(core_salt_len_o), .core_out_valid_i(core_out_valid_i),
    .core_out_ready_o(core_out_ready_o), .core_hash_i(core_hash_i)
`ifdef PBKDF2_ARB_STATS_EN
    , .jobs_done_o(jobs_done_o)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: one job record plus per-requester job state.
  bit          m_busy, m_acc, m_rsp, m_zero, m_err;
  int          m_owner, m_last;
  logic [255:0] m_hash;
  bit          pend[NREQ];
  bit          wrsp[NREQ];
  logic [31:0] it_a[NREQ];
  logic [511:0] pw_a[NREQ];
  logic [511:0] sl_a[NREQ];
  logic [5:0]  ln_a[NREQ];
  int          done_cnt[NREQ];
  int          n_rsp = 0;
  int          g_mode = 0;

  // Emulated core.
  bit          c_busy, c_out;
  int          c_lat;
  logic [255:0] c_hash;

  // Observations for directed tests.
  int          g_cyc = 0, g_inv, g_rr, g_grant_cyc, g_rsp_cyc;
  bit          g_prev_busy = 1'b0, g_rsp_seen;
  logic [NREQ-1:0] g_rsp_v;
  logic [255:0] g_rsp_hash;
  logic        g_rsp_err;
  int          q_grants[$];

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic int rr(input logic [NREQ-1:0] v, input int last);
    for (int i = 1; i <= NREQ; i++) begin
      if (v[(last + i) % NREQ]) return (last + i) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [255:0] hash_fn(input logic [31:0] it, input logic [511:0] p,
                                           input logic [511:0] s, input logic [5:0] l);
    return p[255:0] ^ {p[383:256], p[511:384]} ^ s[255:0] ^ (s[511:256] + {it, 218'd0, l});
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic new_job(input int k, input int it);
    if (it < 0) it_a[k] = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 100000));
    else        it_a[k] = 32'(it);
    pw_a[k] = rnd512();
    sl_a[k] = rnd512();
    ln_a[k] = 6'($urandom_range(0, 63));
    pend[k] = 1'b1;
  endtask

  task automatic drive();
    logic [511:0] r;
    for (int k = 0; k < NREQ; k++) begin
      if (!pend[k] && !wrsp[k] && (g_mode == 2 || (g_mode == 1 && $urandom_range(0, 2) == 0)))
        new_job(k, -1);
      req_v_i[k]                = pend[k];
      req_iters_i[32*k +: 32]   = it_a[k];
      req_pass_i[512*k +: 512]  = pw_a[k];
      req_salt_i[512*k +: 512]  = sl_a[k];
      req_salt_len_i[6*k +: 6]  = ln_a[k];
    end
    rsp_r_i = 4'($urandom);
    core_in_ready_i = !c_busy && ($urandom_range(0, 2) != 0);
    if (c_busy && !c_out) begin
      if (c_lat == 0) c_out = 1'b1;
      else c_lat--;
    end
    r = rnd512();
    core_out_valid_i = c_out;
    core_hash_i = c_out ? c_hash : r[255:0];
  endtask

  // Per-cycle comparison against the model, then advance model and core emulation.
  task automatic sample();
    logic [NREQ-1:0] oh, exp_rr;
    bit exp_inv, exp_our;
    oh = '0;
    oh[m_owner] = 1'b1;
    exp_inv = m_busy && !m_acc && !m_zero;
    exp_rr  = (m_busy && !m_acc && (m_zero || core_in_ready_i)) ? oh : '0;
    exp_our = m_busy && m_acc && !m_rsp && !m_zero && core_out_valid_i;
    check("busy", 512'(busy_o), 512'(m_busy));
    if (m_busy) check("owner", 512'(owner_o), 512'(m_owner));
    check("core_in_valid", 512'(core_in_valid_o), 512'(exp_inv));
    check("req_r", 512'(req_r_o), 512'(exp_rr));
    check("core_iters", 512'(core_iters_o), exp_inv ? 512'(it_a[m_owner]) : 512'd0);
    check("core_pass", core_pass_o, exp_inv ? pw_a[m_owner] : 512'd0);
    check("core_salt", core_salt_o, exp_inv ? sl_a[m_owner] : 512'd0);
    check("core_salt_len", 512'(core_salt_len_o), exp_inv ? 512'(ln_a[m_owner]) : 512'd0);
    check("core_out_ready", 512'(core_out_ready_o), 512'(exp_our));
    check("rsp_v", 512'(rsp_v_o), (m_busy && m_rsp) ? 512'(oh) : 512'd0);
    if (m_busy && m_rsp) begin
      check("rsp_hash", 512'(rsp_hash_o), 512'(m_hash));
      check("rsp_err", 512'(rsp_err_o), 512'(m_err));
    end

    g_cyc++;
    if (core_in_valid_o) g_inv++;
    if (req_r_o != '0) g_rr++;
    if (busy_o && !g_prev_busy) begin
      q_grants.push_back(int'(owner_o));
      g_grant_cyc = g_cyc;
    end
    g_prev_busy = busy_o;
    if (rsp_v_o != '0 && !g_rsp_seen) begin
      g_rsp_seen = 1'b1; g_rsp_v = rsp_v_o; g_rsp_hash = rsp_hash_o;
      g_rsp_err = rsp_err_o; g_rsp_cyc = g_cyc;
    end

    if (!m_busy) begin
      if (req_v_i != '0) begin
        m_owner = rr(req_v_i, m_last);
        m_busy = 1'b1; m_acc = 1'b0; m_rsp = 1'b0;
        m_zero = (it_a[m_owner] == 32'd0);
        m_err  = m_zero;
        m_hash = m_zero ? 256'd0 : hash_fn(it_a[m_owner], pw_a[m_owner], sl_a[m_owner], ln_a[m_owner]);
      end
    end else if (!m_acc) begin
      if (m_zero || core_in_ready_i) begin
        m_acc = 1'b1; m_rsp = m_zero;
        pend[m_owner] = 1'b0; wrsp[m_owner] = 1'b1;
      end
    end else if (!m_rsp) begin
      if (core_out_valid_i) m_rsp = 1'b1;
    end else if (rsp_r_i[m_owner]) begin
      m_busy = 1'b0; m_last = m_owner; wrsp[m_owner] = 1'b0;
      done_cnt[m_owner]++; n_rsp++;
    end

    if (core_in_valid_o && core_in_ready_i) begin
      c_busy = 1'b1;
      c_hash = hash_fn(core_iters_o, core_pass_o, core_salt_o, core_salt_len_o);
      c_lat  = ($urandom_range(0, 15) == 0) ? 100 : $urandom_range(0, 12);
    end
    if (core_out_valid_i && core_out_ready_o) begin
      c_busy = 1'b0; c_out = 1'b0;
    end
  endtask

  task automatic run_cycle();
    @(posedge clk_i); #1;
    drive();
    @(negedge clk_i);
    sample();
  endtask

  task automatic run_until_rsp(input int target, input int budget, input string nm);
    int b = 0;
    while (n_rsp < target && b < budget) begin run_cycle(); b++; end
    check(nm, 512'(n_rsp >= target), 512'd1);
  endtask

  function automatic bit all_quiet();
    bit q = !m_busy;
    for (int k = 0; k < NREQ; k++) if (pend[k] || wrsp[k]) q = 1'b0;
    return q;
  endfunction

  task automatic drain(input int budget);
    int b = 0;
    g_mode = 0;
    while (!all_quiet() && b < budget) begin run_cycle(); b++; end
    check("drain", 512'(all_quiet()), 512'd1);
  endtask

  task automatic reset_obs();
    g_inv = 0; g_rr = 0; g_rsp_seen = 1'b0; g_grant_cyc = 0; g_rsp_cyc = 0;
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_acc = 1'b0; m_rsp = 1'b0; m_zero = 1'b0; m_err = 1'b0;
    m_owner = 0; m_last = NREQ - 1; m_hash = '0;
    c_busy = 1'b0; c_out = 1'b0; c_lat = 0; c_hash = '0;
    for (int k = 0; k < NREQ; k++) begin
      pend[k] = 1'b0; wrsp[k] = 1'b0; done_cnt[k] = 0;
      it_a[k] = '0; pw_a[k] = '0; sl_a[k] = '0; ln_a[k] = '0;
    end
    req_v_i = '0; core_in_ready_i = 1'b0; core_out_valid_i = 1'b0;
    g_prev_busy = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 512'(busy_o), 512'd0);
    check({tag, "_owner"}, 512'(owner_o), 512'd0);
    check({tag, "_rsp_v"}, 512'(rsp_v_o), 512'd0);
    check({tag, "_req_r"}, 512'(req_r_o), 512'd0);
    check({tag, "_in_valid"}, 512'(core_in_valid_o), 512'd0);
    check({tag, "_out_ready"}, 512'(core_out_ready_o), 512'd0);
    check({tag, "_hash"}, 512'(rsp_hash_o), 512'd0);
    check({tag, "_err"}, 512'(rsp_err_o), 512'd0);
    check({tag, "_core_pass"}, core_pass_o, 512'd0);
  endtask

  initial begin
    int t;
    bit found;
    model_reset();
    reset_obs();

    check("pin_rr_all", 512'(rr(4'b1111, 3)), 512'd0);
    check("pin_rr_skip", 512'(rr(4'b1010, 1)), 512'd3);
    check("pin_rr_self", 512'(rr(4'b0100, 2)), 512'd2);
    check("pin_hash", 512'(hash_fn(32'd1, 512'd0, 512'd0, 6'd4)), 512'({32'd1, 218'd0, 6'd4}));

    repeat (3) @(negedge clk_i);
    check_zero("reset");
    rst_ni = 1'b1;

    // All four requesting continuously: grants rotate from requester 0.
    q_grants.delete();
    g_mode = 2;
    run_until_rsp(8, 3000, "order_timeout");
    drain(3000);
    check("order_count", 512'(q_grants.size() >= 8), 512'd1);
    for (int i = 0; i < 8 && i < q_grants.size(); i++)
      check("grant_order", 512'(q_grants[i]), 512'(i % NREQ));

    // Single job on requester 0.
    reset_obs();
    new_job(0, 1);
    ln_a[0] = 6'd4;
    t = n_rsp;
    run_until_rsp(t + 1, 400, "single_timeout");
    drain(400);
    check("single_req_r_pulses", 512'(g_rr), 512'd1);
    check("single_rsp_v", 512'(g_rsp_v), 512'(4'b0001));
    check("single_err", 512'(g_rsp_err), 512'd0);
    check("single_hash", 512'(g_rsp_hash), 512'(hash_fn(32'd1, pw_a[0], sl_a[0], 6'd4)));

    // Zero-iteration job on requester 2 bypasses the core.
    reset_obs();
    new_job(2, 0);
    t = n_rsp;
    run_until_rsp(t + 1, 100, "zero_timeout");
    drain(100);
    check("zero_no_core", 512'(g_inv), 512'd0);
    check("zero_rsp_v", 512'(g_rsp_v), 512'(4'b0100));
    check("zero_hash", 512'(g_rsp_hash), 512'd0);
    check("zero_err", 512'(g_rsp_err), 512'd1);
    check("zero_latency", 512'((g_rsp_cyc - g_grant_cyc) <= 3), 512'd1);

    // Random traffic with random core latency and response back-pressure.
    g_mode = 1;
    t = n_rsp;
    repeat (4000) run_cycle();
    check("random_progress", 512'((n_rsp - t) >= 50), 512'd1);
    drain(3000);

    // Reset while a core job is outstanding.
    g_mode = 1;
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      run_cycle();
      if (m_busy && m_acc && !m_rsp && !m_zero) found = 1'b1;
    end
    check("wait_reached", 512'(found), 512'd1);
    @(posedge clk_i); #3;
    rst_ni = 1'b0;
    #1;
    check_zero("async_reset");
    model_reset();
    g_mode = 0;
    @(negedge clk_i);
    check("reset_held_busy", 512'(busy_o), 512'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    new_job(2, -1);
    new_job(0, -1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      run_cycle();
      if (busy_o) begin
        found = 1'b1;
        check("post_reset_owner", 512'(owner_o), 512'd0);
      end
    end
    check("post_reset_grant", 512'(found), 512'd1);
    drain(1000);

`ifdef PBKDF2_ARB_STATS_EN
    for (int k = 0; k < NREQ; k++)
      check("jobs_done", 512'(jobs_done_o[16*k +: 16]), 512'(done_cnt[k] % 65536));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
